// File: rtl/rv2t_instruction_fetch_pkg.sv
// rv2t_instruction_fetch_pkg
//   Shared definitions for the instruction fetch stage:
//   - XLEN / PC_BITWIDTH datapath widths
//   - fetch FSM state encoding (IDLE / REQ / WAIT)
//   - default reset PC and the sequential PC increment
//   - ack timer width (holds ACK_TIMEOUT values 1..255)
package rv2t_instruction_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int PC_BITWIDTH = 32;
    localparam int TIMER_BITS  = 8;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [PC_BITWIDTH-1:0] DEFAULT_RESET_PC = '0;
    localparam logic [PC_BITWIDTH-1:0] PC_INCR          = PC_BITWIDTH'(4);

endpackage

// File: rtl/rv2t_fetch_ack_timer.sv
// rv2t_fetch_ack_timer
//   Saturating cycle counter used to bound the wait for an instruction
//   memory ack. The count is cleared while clear is high, advances by one
//   per cycle while enable is high, and sticks at its maximum value.
//   terminal is high on the cycle in which the count shows ACK_TIMEOUT-1,
//   i.e. the ACK_TIMEOUT-th enabled cycle since the last clear.
// Ports:
//   clk       core clock
//   reset_n   asynchronous active-low reset
//   clear     synchronous clear (wins over enable)
//   enable    count this cycle
//   terminal  count has reached the timeout limit (qualified by enable)
module rv2t_fetch_ack_timer
    import rv2t_instruction_fetch_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TIMER_BITS-1:0] TERMINAL_COUNT = TIMER_BITS'(ACK_TIMEOUT - 1);

    logic [TIMER_BITS-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TIMER_BITS'(1);
        end
    end

    assign terminal = enable && (count >= TERMINAL_COUNT);

endmodule

// File: rtl/rv2t_instruction_fetch.sv
// rv2t_instruction_fetch
//   Instruction fetch stage feeding decode. Holds the architectural PC,
//   issues one memory read per fetch_enable pulse, and hands the returned
//   word to decode as a one-cycle enable_out pulse with IR_out / PC_out.
//   Jumps from execute redirect the PC; a jump arriving while a fetch is in
//   flight marks that fetch stale so its data is dropped on return.
//   A fetch whose ack does not arrive within ACK_TIMEOUT WAIT cycles is
//   abandoned with a one-cycle exception_fetch_timeout pulse.
//
//   Handshake: fetch_enable is only honoured when fetch_busy is low;
//   mem_read_en is a single-cycle strobe and exactly one mem_read_ack is
//   expected in return; enable_out is a single-cycle valid with no ready,
//   and IR_out / PC_out are meaningful only while it is high.
//
//   Build option RV2T_FETCH_MISALIGN_CHECK_EN:
//     defined   - a fetch from a PC with nonzero bits [1:0] issues no read,
//                 pulses exception_instruction_addr_misaligned and reports
//                 the faulty PC on PC_out.
//     undefined - mem_read_addr[1:0] is forced to 0 and the misaligned
//                 exception output is tied low.
//
// Ports:
//   clk, reset_n, sync_reset               clock, async reset, sync reset
//   fetch_enable                           start one fetch (IDLE only)
//   jump_en, jump_addr                     redirect from execute
//   mem_read_en, mem_read_addr             read strobe / byte address
//   mem_read_ack, mem_read_data            read return
//   enable_out, IR_out, PC_out             delivery to decode
//   fetch_busy                             high in REQ / WAIT
//   exception_fetch_timeout                one-cycle ack timeout pulse
//   exception_instruction_addr_misaligned  one-cycle misaligned pulse
//   state_dbg                              current FSM state encoding
module rv2t_instruction_fetch
    import rv2t_instruction_fetch_pkg::*;
#(
    parameter logic [PC_BITWIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int                     ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_reset,
    input  logic                   fetch_enable,
    input  logic                   jump_en,
    input  logic [PC_BITWIDTH-1:0] jump_addr,
    output logic                   mem_read_en,
    output logic [PC_BITWIDTH-1:0] mem_read_addr,
    input  logic                   mem_read_ack,
    input  logic [XLEN-1:0]        mem_read_data,
    output logic                   enable_out,
    output logic [XLEN-1:0]        IR_out,
    output logic [PC_BITWIDTH-1:0] PC_out,
    output logic                   fetch_busy,
    output logic                   exception_fetch_timeout,
    output logic                   exception_instruction_addr_misaligned,
    output logic [1:0]             state_dbg
);

    fetch_state_e           state, state_next;
    logic [PC_BITWIDTH-1:0] pc_reg, pc_next;
    logic [PC_BITWIDTH-1:0] jump_target, target_next;
    logic                   squash, squash_next;
    logic [PC_BITWIDTH-1:0] fetch_addr;
    logic [PC_BITWIDTH-1:0] redirect_pc;
    logic                   redirect_pending;

    logic                   rd_en_next;
    logic [PC_BITWIDTH-1:0] rd_addr_next;
    logic                   en_next;
    logic [XLEN-1:0]        ir_next;
    logic [PC_BITWIDTH-1:0] pcout_next;
    logic                   timeout_next;
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
    logic                   misaligned_next;
    logic                   misaligned_q;
`endif

    logic                   timer_clear;
    logic                   timer_enable;
    logic                   timer_tc;

    // The timer runs only in WAIT and restarts from zero for every fetch.
    assign timer_clear  = sync_reset || (state != FETCH_WAIT);
    assign timer_enable = (state == FETCH_WAIT);

    rv2t_fetch_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_tc)
    );

    // A jump in the same cycle as fetch_enable wins over the held PC.
    assign fetch_addr = jump_en ? jump_addr : pc_reg;

    // When an in-flight fetch ends, a same-cycle jump is newer than any
    // previously latched target, so it takes precedence.
    assign redirect_pending = squash || jump_en;
    assign redirect_pc      = jump_en ? jump_addr : jump_target;

    always_comb begin
        state_next   = state;
        pc_next      = pc_reg;
        target_next  = jump_target;
        squash_next  = squash;
        rd_en_next   = 1'b0;
        rd_addr_next = mem_read_addr;
        en_next      = 1'b0;
        ir_next      = IR_out;
        pcout_next   = PC_out;
        timeout_next = 1'b0;
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
        misaligned_next = 1'b0;
`endif

        case (state)
            FETCH_IDLE: begin
                if (jump_en) begin
                    pc_next = jump_addr;
                end
                if (fetch_enable) begin
                    // The read strobe is launched on entry to REQ so that it
                    // is visible (registered) for the whole REQ cycle.
                    state_next  = FETCH_REQ;
                    squash_next = 1'b0;
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
                    rd_addr_next = fetch_addr;
                    rd_en_next   = (fetch_addr[1:0] == 2'b00);
`else
                    rd_addr_next = fetch_addr & ~PC_BITWIDTH'(3);
                    rd_en_next   = 1'b1;
`endif
                end
            end

            FETCH_REQ: begin
                state_next = FETCH_WAIT;
                // The read is already out, so a jump here stales it.
                if (jump_en) begin
                    squash_next = 1'b1;
                    target_next = jump_addr;
                end
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
                if (pc_reg[1:0] != 2'b00) begin
                    state_next      = FETCH_IDLE;
                    misaligned_next = 1'b1;
                    pcout_next      = pc_reg;
                    squash_next     = 1'b0;
                    if (jump_en) begin
                        pc_next = jump_addr;
                    end
                end
`endif
            end

            FETCH_WAIT: begin
                if (jump_en) begin
                    squash_next = 1'b1;
                    target_next = jump_addr;
                end
                if (mem_read_ack) begin
                    state_next  = FETCH_IDLE;
                    squash_next = 1'b0;
                    if (redirect_pending) begin
                        pc_next = redirect_pc;
                    end else begin
                        en_next    = 1'b1;
                        ir_next    = mem_read_data;
                        pcout_next = pc_reg;
                        pc_next    = pc_reg + PC_INCR;
                    end
                end else if (timer_tc) begin
                    state_next   = FETCH_IDLE;
                    squash_next  = 1'b0;
                    timeout_next = 1'b1;
                    if (redirect_pending) begin
                        pc_next = redirect_pc;
                    end
                end
            end

            default: begin
                state_next  = FETCH_IDLE;
                squash_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= FETCH_IDLE;
            pc_reg                  <= RESET_PC;
            jump_target             <= '0;
            squash                  <= 1'b0;
            mem_read_en             <= 1'b0;
            mem_read_addr           <= '0;
            enable_out              <= 1'b0;
            IR_out                  <= '0;
            PC_out                  <= '0;
            exception_fetch_timeout <= 1'b0;
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
            misaligned_q            <= 1'b0;
`endif
        end else if (sync_reset) begin
            state                   <= FETCH_IDLE;
            pc_reg                  <= RESET_PC;
            jump_target             <= '0;
            squash                  <= 1'b0;
            mem_read_en             <= 1'b0;
            mem_read_addr           <= '0;
            enable_out              <= 1'b0;
            IR_out                  <= '0;
            PC_out                  <= '0;
            exception_fetch_timeout <= 1'b0;
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
            misaligned_q            <= 1'b0;
`endif
        end else begin
            state                   <= state_next;
            pc_reg                  <= pc_next;
            jump_target             <= target_next;
            squash                  <= squash_next;
            mem_read_en             <= rd_en_next;
            mem_read_addr           <= rd_addr_next;
            enable_out              <= en_next;
            IR_out                  <= ir_next;
            PC_out                  <= pcout_next;
            exception_fetch_timeout <= timeout_next;
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
            misaligned_q            <= misaligned_next;
`endif
        end
    end

`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
    assign exception_instruction_addr_misaligned = misaligned_q;
`else
    assign exception_instruction_addr_misaligned = 1'b0;
`endif

    assign fetch_busy = (state != FETCH_IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_rv2t_instruction_fetch.sv
// tb_rv2t_instruction_fetch
//   Self-checking bench for rv2t_instruction_fetch. Driver tasks issue
//   fetches and push the expected DUT events (read strobe, delivery,
//   timeout, misaligned fault) into exp_q; a monitor on the falling edge
//   pops and compares every event the DUT presents.
module tb_rv2t_instruction_fetch;
    import rv2t_instruction_fetch_pkg::*;

    localparam int          ACK_TO = 255;
    localparam logic [31:0] RST_PC = 32'h0;

    localparam logic [1:0] EV_READ = 2'd0;
    localparam logic [1:0] EV_DLVR = 2'd1;
    localparam logic [1:0] EV_TOUT = 2'd2;
    localparam logic [1:0] EV_MISA = 2'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        fetch_enable = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        mem_read_ack = 1'b0;
    logic [31:0] mem_read_data = '0;
    logic        mem_read_en;
    logic [31:0] mem_read_addr;
    logic        enable_out;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic        fetch_busy;
    logic        exception_fetch_timeout;
    logic        exception_instruction_addr_misaligned;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    rv2t_instruction_fetch #(
        .RESET_PC    (RST_PC),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk                                   (clk),
        .reset_n                               (reset_n),
        .sync_reset                            (sync_reset),
        .fetch_enable                          (fetch_enable),
        .jump_en                               (jump_en),
        .jump_addr                             (jump_addr),
        .mem_read_en                           (mem_read_en),
        .mem_read_addr                         (mem_read_addr),
        .mem_read_ack                          (mem_read_ack),
        .mem_read_data                         (mem_read_data),
        .enable_out                            (enable_out),
        .IR_out                                (IR_out),
        .PC_out                                (PC_out),
        .fetch_busy                            (fetch_busy),
        .exception_fetch_timeout               (exception_fetch_timeout),
        .exception_instruction_addr_misaligned (exception_instruction_addr_misaligned),
        .state_dbg                             (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [65:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_model;

    function automatic logic [65:0] ev(input logic [1:0] kind, input logic [31:0] a,
                                       input logic [31:0] b);
        return {kind, a, b};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT event must match the oldest expected event.
    always @(negedge clk) begin
        logic [65:0] act;
        logic [65:0] exp;
        if (reset_n && (mem_read_en || enable_out || exception_fetch_timeout ||
                        exception_instruction_addr_misaligned)) begin
            if (mem_read_en)
                act = ev(EV_READ, mem_read_addr, 32'h0);
            else if (enable_out)
                act = ev(EV_DLVR, PC_out, IR_out);
            else if (exception_fetch_timeout)
                act = ev(EV_TOUT, 32'h0, 32'h0);
            else
                act = ev(EV_MISA, PC_out, 32'h0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %h expected none at %0t", act, $time);
            end else begin
                exp = exp_q.pop_front();
                check("event", act, exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fetch_busy && n < 400) begin
            step();
            n++;
        end
        if (fetch_busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: fetch_busy got 1 expected 0 after %0d cycles", n);
        end
    endtask

    task automatic idle_jump(input logic [31:0] addr);
        wait_idle();
        jump_en   = 1'b1;
        jump_addr = addr;
        step();
        jump_en  = 1'b0;
        pc_model = addr;
    endtask

    // One fetch. ack_dly: WAIT-cycle index of the ack (0 = earliest legal).
    // mid/mid_idx/mid_addr: optional jump during WAIT. no_ack: force timeout.
    task automatic do_fetch(input bit use_jump, input logic [31:0] jaddr,
                            input int ack_dly, input bit no_ack,
                            input bit mid, input int mid_idx,
                            input logic [31:0] mid_addr, input logic [31:0] data,
                            input bit late_ack);
        logic [31:0] addr;
        logic [31:0] tgt;
        bit          squashed;
        squashed = 1'b0;
        tgt      = '0;
        wait_idle();
        addr     = use_jump ? jaddr : pc_model;
        pc_model = addr;
        fetch_enable = 1'b1;
        jump_en      = use_jump;
        jump_addr    = jaddr;
`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) begin
            exp_q.push_back(ev(EV_MISA, addr, 32'h0));
            step();
            fetch_enable = 1'b0;
            jump_en      = 1'b0;
            step();
            return;
        end
`endif
        exp_q.push_back(ev(EV_READ, {addr[31:2], 2'b00}, 32'h0));
        step();
        fetch_enable = 1'b0;
        jump_en      = 1'b0;
        step();
        for (int i = 0; i < ACK_TO; i++) begin
            jump_en       = mid && (i == mid_idx);
            jump_addr     = mid_addr;
            mem_read_ack  = !no_ack && (i == ack_dly);
            mem_read_data = mem_read_ack ? data : $urandom();
            if (jump_en) begin
                squashed = 1'b1;
                tgt      = mid_addr;
            end
            if (mem_read_ack) begin
                if (squashed) begin
                    pc_model = tgt;
                end else begin
                    exp_q.push_back(ev(EV_DLVR, pc_model, data));
                    pc_model = pc_model + 32'd4;
                end
                step();
                break;
            end
            step();
        end
        jump_en      = 1'b0;
        mem_read_ack = 1'b0;
        if (no_ack) begin
            exp_q.push_back(ev(EV_TOUT, 32'h0, 32'h0));
            if (squashed) pc_model = tgt;
            if (late_ack) begin
                mem_read_ack  = 1'b1;
                mem_read_data = $urandom();
                step();
                mem_read_ack = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFF8;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_read_en"}, 66'(mem_read_en), 66'(0));
        check({tag, "_mem_read_addr"}, 66'(mem_read_addr), 66'(0));
        check({tag, "_enable_out"}, 66'(enable_out), 66'(0));
        check({tag, "_IR_out"}, 66'(IR_out), 66'(0));
        check({tag, "_PC_out"}, 66'(PC_out), 66'(0));
        check({tag, "_fetch_busy"}, 66'(fetch_busy), 66'(0));
        check({tag, "_timeout"}, 66'(exception_fetch_timeout), 66'(0));
        check({tag, "_misaligned"}, 66'(exception_instruction_addr_misaligned), 66'(0));
    endtask

    // Start a fetch, abandon it two cycles into WAIT with the given reset kind.
    task automatic reset_mid_wait(input bit use_sync);
        idle_jump(32'h0000_0040);
        exp_q.push_back(ev(EV_READ, 32'h0000_0040, 32'h0));
        fetch_enable = 1'b1;
        step();
        fetch_enable = 1'b0;
        step();
        step();
        if (use_sync) begin
            sync_reset = 1'b1;
            step();
            sync_reset = 1'b0;
            check_outputs_zero("sync_rst");
        end else begin
            reset_n = 1'b0;
            #1;
            check_outputs_zero("async_rst");
            step();
            reset_n = 1'b1;
        end
        pc_model = RST_PC;
        // A late ack after reset must be ignored.
        mem_read_ack = 1'b1;
        step();
        mem_read_ack = 1'b0;
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h0000_0093, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        pc_model = RST_PC;
        reset_n  = 1'b0;
        repeat (3) step();
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Basic fetch, earliest ack, then sequential fetch.
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h0000_0013, 0);
        do_fetch(0, 0, 1, 0, 0, 0, 0, 32'h0040_0093, 0);
        // Fetch with simultaneous jump.
        do_fetch(1, 32'h0000_0100, 2, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
        // Jump during WAIT, ack two cycles later: dropped, next reads 0x200.
        do_fetch(0, 0, 2, 0, 1, 0, 32'h0000_0200, 32'h1111_1111, 0);
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h2222_2222, 0);
        // Jump in the same cycle as the ack.
        do_fetch(0, 0, 3, 0, 1, 3, 32'h0000_0300, 32'h3333_3333, 0);
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h4444_4444, 0);
        // Timeout with a late ack, then PC unchanged.
        do_fetch(0, 0, 0, 1, 0, 0, 0, 0, 1);
        check("busy_after_timeout", 66'(fetch_busy), 66'(0));
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h5555_5555, 0);
        // Ack on the last WAIT cycle before the limit still delivers.
        do_fetch(0, 0, ACK_TO - 1, 0, 0, 0, 0, 32'h6666_6666, 0);
        // PC wrap.
        idle_jump(32'hFFFF_FFFC);
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h7777_7777, 0);
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h8888_8888, 0);
        // Misaligned target.
        idle_jump(32'h0000_0102);
        do_fetch(0, 0, 0, 0, 0, 0, 0, 32'h9999_9999, 0);
        // Resets in the middle of WAIT.
        reset_mid_wait(0);
        reset_mid_wait(1);

        // Randomized fetches.
        for (int n = 0; n < 60; n++) begin
            bit          uj, na, md;
            int          dly, midx;
            if ($urandom_range(0, 4) == 0) idle_jump(rand_addr());
            uj   = ($urandom_range(0, 3) == 0);
            na   = ($urandom_range(0, 11) == 0);
            md   = ($urandom_range(0, 3) == 0);
            dly  = $urandom_range(0, 6);
            midx = na ? $urandom_range(0, ACK_TO - 1) : $urandom_range(0, dly);
            do_fetch(uj, rand_addr(), dly, na, md, midx, rand_addr(), $urandom(),
                     bit'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (4) step();
        check("queue_drained", 66'(exp_q.size()), 66'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv2t_instruction_fetch.md
Name: rv2t_instruction_fetch

Overview:
Instruction fetch stage directly upstream of the decode stage. Holds the architectural PC and issues one read per controller request on the instruction-memory port. Delivers the returned word plus its PC to decode as a one-cycle enable_out pulse with IR_out/PC_out. Applies jump redirects from execute, squashes in-flight fetches made stale by a redirect, and flags memory-ack timeouts.

Parameters:
RESET_PC, 0, PC value loaded on reset and on sync_reset
ACK_TIMEOUT, 255, cycles in WAIT without an ack before the fetch is aborted (1..255)

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
sync_reset  input  1  synchronous reset, same effect as reset_n
fetch_enable  input  1  controller pulse: start one fetch
jump_en  input  1  redirect request from execute
jump_addr  input  PC_BITWIDTH  redirect target
mem_read_en  output  1  one-cycle read strobe to instruction memory
mem_read_addr  output  PC_BITWIDTH  byte address of the read
mem_read_ack  input  1  read data valid
mem_read_data  input  XLEN  returned instruction word
enable_out  output  1  one-cycle valid pulse to decode
IR_out  output  XLEN  fetched instruction
PC_out  output  PC_BITWIDTH  PC of IR_out
fetch_busy  output  1  high in REQ/WAIT
exception_fetch_timeout  output  1  one-cycle pulse on ack timeout
exception_instruction_addr_misaligned  output  1  see Optional Feature

Behaviour:
- Reset (reset_n low, async; or sync_reset high at a clock edge): PC_reg=RESET_PC, state=IDLE, all outputs 0, timer 0, squash flag 0.
- States: IDLE, REQ, WAIT. All outputs are registered.
- IDLE:
  - jump_en alone: PC_reg<=jump_addr.
  - fetch_enable: state<=REQ. If jump_en is high in the same cycle, the fetch uses jump_addr and PC_reg<=jump_addr. Jump has priority.
- REQ (1 cycle): mem_read_en=1, mem_read_addr=PC_reg; state<=WAIT; timer cleared.
- WAIT: timer increments each cycle.
  - mem_read_ack: if the squash flag is clear, IR_out<=mem_read_data, PC_out<=PC_reg, enable_out=1 next cycle, PC_reg<=PC_reg+4. If the squash flag is set, the data is dropped, enable_out stays 0, PC_reg<=the latched jump target and the flag clears. state<=IDLE either way.
  - jump_en: latch jump_addr and set the squash flag. If jump_en arrives in the same cycle as the ack, the squash applies to that ack.
  - timer reaches ACK_TIMEOUT with no ack: exception_fetch_timeout pulse, no enable_out, PC_reg unchanged (or the latched jump target if the squash flag is set), state<=IDLE.
- Latency: fetch_enable at cycle N gives mem_read_en at N+1. The earliest legal ack is N+2, giving enable_out at N+3.
- mem_read_ack outside WAIT is ignored. fetch_enable outside IDLE is ignored; the controller must wait for fetch_busy low.
- PC arithmetic wraps modulo 2^PC_BITWIDTH.
- IR_out/PC_out hold their last value between pulses; decode samples them only with enable_out.
- Reset mid-WAIT abandons the fetch. A late ack after reset is ignored because state is IDLE.

Optional Feature:
RV2T_FETCH_MISALIGN_CHECK_EN
- Defined: in REQ, if PC_reg[1:0]!=0, no mem_read_en is issued. Instead exception_instruction_addr_misaligned pulses for one cycle, PC_out<=the faulty PC, enable_out stays 0, state<=IDLE.
- Undefined: mem_read_addr[1:0] is forced to 0 and exception_instruction_addr_misaligned is tied 0.

Decomposition:
- Shared package/header: fetch state encoding (IDLE/REQ/WAIT), default RESET_PC, PC increment constant (4). XLEN and PC_BITWIDTH come from the existing common header.
- One sub-module: rv2t_fetch_ack_timer, a saturating counter with clear/enable inputs and a terminal-count output compared against ACK_TIMEOUT.

Test Plan:
- Reset then fetch_enable at cycle 1, ack at cycle 3 with data 0x00000013 -> mem_read_addr=0x0 at cycle 2; enable_out at cycle 4 with IR_out=0x13, PC_out=0x0; next fetch reads 0x4.
- fetch_enable together with jump_en, jump_addr=0x100 -> mem_read_addr=0x100; PC_out=0x100 on completion.
- jump_en (0x200) during WAIT, ack 2 cycles later -> no enable_out pulse; next fetch reads 0x200.
- No ack for 255 cycles in WAIT -> exception_fetch_timeout pulses once; fetch_busy falls; PC_reg unchanged; a late ack is ignored.
- reset_n asserted in WAIT -> all outputs 0 immediately; after release the first fetch reads RESET_PC.
- With the macro defined, jump to 0x102 then fetch -> no mem_read_en; misaligned pulse; PC_out=0x102.
